// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic PE array: loads A and B, streams them skewed
// onto the array edges, then holds results until acknowledged. Optional macro: SYSTOLIC_FEEDER_JOBCNT_EN.
module systolic_feeder #(
    parameter int BITWIDTH = 4,
    parameter int N        = 4
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    input  logic                       i_load_valid,
    output logic                       o_load_ready,
    input  logic [N*N*BITWIDTH-1:0]    i_mat_a,
    input  logic [N*N*BITWIDTH-1:0]    i_mat_b,
    output logic                       o_doProcess,
    output logic [N*BITWIDTH-1:0]      o_a,
    output logic [N*BITWIDTH-1:0]      o_b,
    output logic                       o_busy,
    output logic                       o_done,
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    input  logic                       i_ack,
    output logic [15:0]                o_job_count
`else
    input  logic                       i_ack
`endif
);

    localparam int MW = N * N * BITWIDTH;
    localparam int VW = N * BITWIDTH;
    localparam int TW = $clog2(3 * N - 2);
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FEED = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_t;
    logic [MW-1:0]   r_mat_a;
    logic [MW-1:0]   r_mat_b;

    // Left edge at step t: row i carries A[i][t-i] while that column index is in range.
    function automatic logic [VW-1:0] skew_a(input logic [MW-1:0] m, input logic [TW-1:0] t);
        logic [VW-1:0] v;
        int k;
        v = {VW{1'b0}};
        for (int i = 0; i < N; i++) begin
            k = int'(t) - i;
            if (k >= 0 && k < N) begin
                v[i*BITWIDTH +: BITWIDTH] = m[(i*N + k)*BITWIDTH +: BITWIDTH];
            end else begin
                v[i*BITWIDTH +: BITWIDTH] = {BITWIDTH{1'b0}};
            end
        end
        return v;
    endfunction

    // Top edge at step t: column j carries B[t-j][j] while that row index is in range.
    function automatic logic [VW-1:0] skew_b(input logic [MW-1:0] m, input logic [TW-1:0] t);
        logic [VW-1:0] v;
        int k;
        v = {VW{1'b0}};
        for (int j = 0; j < N; j++) begin
            k = int'(t) - j;
            if (k >= 0 && k < N) begin
                v[j*BITWIDTH +: BITWIDTH] = m[(k*N + j)*BITWIDTH +: BITWIDTH];
            end else begin
                v[j*BITWIDTH +: BITWIDTH] = {BITWIDTH{1'b0}};
            end
        end
        return v;
    endfunction

    // Job sequencer; every output is registered and loaded with the value for the coming step.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state      <= S_IDLE;
            r_t          <= {TW{1'b0}};
            r_mat_a      <= {MW{1'b0}};
            r_mat_b      <= {MW{1'b0}};
            o_load_ready <= 1'b1;
            o_doProcess  <= 1'b0;
            o_a          <= {VW{1'b0}};
            o_b          <= {VW{1'b0}};
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load_valid) begin
                        r_state      <= S_FEED;
                        r_t          <= {TW{1'b0}};
                        r_mat_a      <= i_mat_a;
                        r_mat_b      <= i_mat_b;
                        o_load_ready <= 1'b0;
                        o_doProcess  <= 1'b1;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_a          <= skew_a(i_mat_a, {TW{1'b0}});
                        o_b          <= skew_b(i_mat_b, {TW{1'b0}});
                    end else begin
                        o_load_ready <= 1'b1;
                        o_doProcess  <= 1'b0;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b0;
                        o_a          <= {VW{1'b0}};
                        o_b          <= {VW{1'b0}};
                    end
                end
                S_FEED: begin
                    if (r_t == T_LAST) begin
                        // Zero operands in DONE keep the accumulators frozen on their final sums.
                        r_state      <= S_DONE;
                        r_t          <= {TW{1'b0}};
                        o_load_ready <= 1'b0;
                        o_doProcess  <= 1'b1;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b1;
                        o_a          <= {VW{1'b0}};
                        o_b          <= {VW{1'b0}};
                    end else begin
                        r_t          <= r_t + {{(TW-1){1'b0}}, 1'b1};
                        o_a          <= skew_a(r_mat_a, r_t + {{(TW-1){1'b0}}, 1'b1});
                        o_b          <= skew_b(r_mat_b, r_t + {{(TW-1){1'b0}}, 1'b1});
                    end
                end
                S_DONE: begin
                    if (i_ack) begin
                        r_state      <= S_IDLE;
                        o_load_ready <= 1'b1;
                        o_doProcess  <= 1'b0;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b0;
                        o_a          <= {VW{1'b0}};
                        o_b          <= {VW{1'b0}};
                    end else begin
                        o_done       <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_t          <= {TW{1'b0}};
                    o_load_ready <= 1'b1;
                    o_doProcess  <= 1'b0;
                    o_busy       <= 1'b0;
                    o_done       <= 1'b0;
                    o_a          <= {VW{1'b0}};
                    o_b          <= {VW{1'b0}};
                end
            endcase
        end
    end

`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    // Completed-job counter, stepped on each acknowledged DONE and free to wrap.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_job_count <= 16'd0;
        end else if (r_state == S_DONE && i_ack) begin
            o_job_count <= o_job_count + 16'd1;
        end else begin
            o_job_count <= o_job_count;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: a behavioural PE array turns the feeder streams
// into results, and a monitor compares them with queued hand-derived products on o_done.
`timescale 1ns/1ps
module tb_systolic_feeder;
    localparam int BW = 4;
    localparam int N  = 4;
    localparam int MW = N * N * BW;
    localparam int VW = N * BW;
    localparam int YW = 16;
    typedef logic [N*N*YW-1:0] res_t;

    logic          i_clk = 1'b0;
    logic          i_arst = 1'b1;
    logic          i_load_valid = 1'b0;
    logic          o_load_ready;
    logic [MW-1:0] i_mat_a = '0;
    logic [MW-1:0] i_mat_b = '0;
    logic          o_doProcess;
    logic [VW-1:0] o_a;
    logic [VW-1:0] o_b;
    logic          o_busy;
    logic          o_done;
    logic          i_ack = 1'b0;
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    logic [15:0]   o_job_count;
`endif

    int checks = 0;
    int errors = 0;
    res_t exp_q[$];

    systolic_feeder #(.BITWIDTH(BW), .N(N)) dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_mat_a(i_mat_a), .i_mat_b(i_mat_b), .o_doProcess(o_doProcess), .o_a(o_a), .o_b(o_b),
        .o_busy(o_busy), .o_done(o_done),
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
        .o_job_count(o_job_count),
`endif
        .i_ack(i_ack)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural PE array: operands pass right/down one PE per cycle; doProcess=0 clears.
    logic [BW-1:0] a_pipe [N][N];
    logic [BW-1:0] b_pipe [N][N];
    logic [YW-1:0] acc    [N][N];
    always @(posedge i_clk or posedge i_arst) begin : pe_array
        logic [BW-1:0] a_in, b_in;
        if (i_arst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_pipe[i][j] <= '0; b_pipe[i][j] <= '0; acc[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_in = (j == 0) ? o_a[i*BW +: BW] : a_pipe[i][j-1];
                    b_in = (i == 0) ? o_b[j*BW +: BW] : b_pipe[i-1][j];
                    a_pipe[i][j] <= a_in;
                    b_pipe[i][j] <= b_in;
                    acc[i][j] <= o_doProcess ? acc[i][j] + YW'(a_in) * YW'(b_in) : '0;
                end
        end
    end

    function automatic res_t pack_y();
        res_t y;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) y[(i*N+j)*YW +: YW] = acc[i][j];
        return y;
    endfunction

    function automatic logic [MW-1:0] mat_fill(input int v);
        logic [MW-1:0] m;
        for (int k = 0; k < N*N; k++) m[k*BW +: BW] = BW'(v);
        return m;
    endfunction

    function automatic logic [MW-1:0] mat_diag(input int scale_by_row);
        logic [MW-1:0] m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[(r*N+c)*BW +: BW] = (r == c) ? BW'(scale_by_row ? r + 1 : 1) : BW'(0);
        return m;
    endfunction

    function automatic res_t res_of(input int mode, input int v);
        res_t y;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                case (mode)
                    0: y[(r*N+c)*YW +: YW] = (r == c) ? YW'(1) : YW'(0);
                    1: y[(r*N+c)*YW +: YW] = YW'(v);
                    default: y[(r*N+c)*YW +: YW] = YW'(r + 1);
                endcase
        return y;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: each rising o_done pops one expected result matrix.
    logic prev_done = 1'b0;
    always @(negedge i_clk) begin
        if (o_done && !prev_done) begin
            res_t e, g;
            checks++;
            g = pack_y();
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got %h want no result", g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL result: got %h want %h", g, e);
                end
            end
        end
        prev_done <= o_done;
    end

    task automatic load_job(input logic [MW-1:0] a, input logic [MW-1:0] b);
        chk("ready_before_load", 64'(o_load_ready), 64'd1);
        i_mat_a = a; i_mat_b = b; i_load_valid = 1'b1;
        @(negedge i_clk);
        i_load_valid = 1'b0;
    endtask

    task automatic ack_job();
        i_ack = 1'b1;
        @(negedge i_clk);
        i_ack = 1'b0;
    endtask

    // Waits for o_done from FEED cycle 'start'; optionally injects ignored load/ack pulses.
    task automatic wait_done(input int start, input bit inject, output int busy_n, output int done_cyc);
        busy_n = 0; done_cyc = 0;
        for (int c = start; c < start + 40; c++) begin
            if (o_done) begin done_cyc = c; break; end
            busy_n += int'(o_busy);
            if (inject) begin
                if (c == 3) begin
                    i_load_valid = 1'b1; i_mat_a = mat_fill(15); i_mat_b = mat_fill(15); i_ack = 1'b1;
                end else if (c == 4) begin
                    i_load_valid = 1'b0; i_ack = 1'b0;
                end else if (c == 10) begin
                    i_ack = 1'b1;
                end
            end
            @(negedge i_clk);
        end
        i_ack = 1'b0;
    endtask

    initial begin
        int busy_n, done_cyc;
        bit hold_ok;
        repeat (2) @(negedge i_clk);
        chk("reset_outputs", {o_load_ready, o_doProcess, o_busy, o_done, o_a, o_b}, {4'b1000, 32'h0});
        i_arst = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("idle_after_release", {o_load_ready, o_doProcess, o_busy, o_done, o_a, o_b}, {4'b1000, 32'h0});

        // Job 1: identity x identity.
        exp_q.push_back(res_of(0, 0));
        load_job(mat_diag(0), mat_diag(0));
        chk("ident_t0_ab", {o_a, o_b}, {16'h0001, 16'h0001});
        wait_done(1, 1'b0, busy_n, done_cyc);
        chk("ident_busy_cycles", 64'(busy_n), 64'd10);
        chk("ident_done_cycle", 64'(done_cyc), 64'd11);
        ack_job();

        // Job 2: all 3 x all 5, skew checks, hold, then ack with a competing load.
        exp_q.push_back(res_of(1, 60));
        load_job(mat_fill(3), mat_fill(5));
        chk("fill_t0_ab", {o_a, o_b, o_doProcess}, {16'h0003, 16'h0005, 1'b1});
        @(negedge i_clk);
        chk("fill_t1_ab", {o_a, o_b}, {16'h0033, 16'h0055});
        repeat (2) @(negedge i_clk);
        chk("fill_t3_ab", {o_a, o_b}, {16'h3333, 16'h5555});
        wait_done(4, 1'b0, busy_n, done_cyc);
        chk("fill_done_cycle", 64'(done_cyc), 64'd11);
        hold_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (pack_y() !== res_of(1, 60) || o_done !== 1'b1 || o_doProcess !== 1'b1) hold_ok = 1'b0;
            @(negedge i_clk);
        end
        chk("done_hold_20", 64'(hold_ok), 64'd1);
        exp_q.push_back(res_of(1, 1));
        i_mat_a = mat_fill(1); i_mat_b = mat_diag(0); i_load_valid = 1'b1; i_ack = 1'b1;
        @(negedge i_clk);
        i_ack = 1'b0;
        chk("ack_to_idle", {o_done, o_busy, o_doProcess, o_load_ready, pack_y() == res_of(1, 60)}, 5'b00011);
        @(negedge i_clk);
        i_load_valid = 1'b0;
        chk("load_after_ack", {o_busy, pack_y() == res_t'(0)}, 2'b11);

        // Job 3: ignored load/ack pulses in FEED and ack on the FEED->DONE edge.
        wait_done(1, 1'b1, busy_n, done_cyc);
        chk("pulse_busy_cycles", 64'(busy_n), 64'd10);
        chk("pulse_done_cycle", 64'(done_cyc), 64'd11);
        @(negedge i_clk);
        chk("done_after_edge_ack", 64'(o_done), 64'd1);
        ack_job();

        // Aborted job: async reset at t=5 of FEED.
        load_job(mat_fill(15), mat_fill(15));
        repeat (5) @(negedge i_clk);
        chk("feed_t5_busy", 64'(o_busy), 64'd1);
        i_arst = 1'b1;
        #1;
        chk("async_reset", {o_load_ready, o_doProcess, o_busy, o_done, o_a, o_b}, {4'b1000, 32'h0});
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
        chk("jobcnt_reset", 64'(o_job_count), 64'd0);
`endif
        @(negedge i_clk);
        i_arst = 1'b0;
        @(negedge i_clk);

        // Job 4: diag(1..4) x all ones.
        exp_q.push_back(res_of(2, 0));
        load_job(mat_diag(1), mat_fill(1));
        wait_done(1, 1'b0, busy_n, done_cyc);
        chk("diag_done_cycle", 64'(done_cyc), 64'd11);
        ack_job();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
        chk("jobcnt_final", 64'(o_job_count), 64'd1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
